// File: rtl/breadboard_pkg.sv
// breadboard_pkg: shared state encoding and default sizes for the breadboard sweep controller.
package breadboard_pkg;
    localparam int DEFAULT_NUM_IN  = 4;
    localparam int DEFAULT_NUM_OUT = 10;
    localparam int NUM_VEC         = 2 ** DEFAULT_NUM_IN;
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, EMIT, DONE} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: load/enable counter whose terminal-count flag marks the last settle cycle.
module settle_timer #(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    assign tc = count == W'(LIMIT - 1);
    always_ff @(posedge clk) begin
        if (rst || load) count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/breadboard_sweep_ctrl.sv
// breadboard_sweep_ctrl: clocked truth-table sweep of the breadboard with valid/ready result port.
// Optional build macro SWEEP_SIGNATURE_EN adds a rotate-xor signature over all captured outputs.
module breadboard_sweep_ctrl
    import breadboard_pkg::*;
#(
    parameter int NUM_IN        = DEFAULT_NUM_IN,
    parameter int NUM_OUT       = DEFAULT_NUM_OUT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [NUM_IN-1:0]  rd_index,
    output logic [NUM_OUT-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic [NUM_OUT-1:0] signature
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    state_t state, state_nx;
    logic [NUM_IN-1:0] index;
    logic tc, last, go;
    assign last     = index == {NUM_IN{1'b1}};
    assign go       = state == IDLE && start && !abort;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign rd_valid = state == EMIT;
    assign dut_in   = (state == SETTLE || state == CAPTURE || state == EMIT) ? index : '0;
    settle_timer #(.LIMIT(SETTLE_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .load(state != SETTLE),
        .en  (state == SETTLE),
        .tc  (tc)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETTLE : IDLE;
            SETTLE:  state_nx = tc ? CAPTURE : SETTLE;
            CAPTURE: state_nx = EMIT;
            EMIT:    state_nx = !rd_ready ? EMIT : last ? DONE : SETTLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            rd_index <= '0;
            rd_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) index <= '0;
            else if (state == EMIT && rd_ready && !last && !abort) index <= index + 1'b1;
            if (state == CAPTURE) begin
                rd_data  <= dut_out;
                rd_index <= index;
            end
        end
    end
`ifdef SWEEP_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (rst || go) signature <= '0;
        else if (state == CAPTURE) signature <= {signature[NUM_OUT-2:0], signature[NUM_OUT-1]} ^ dut_out;
    end
`else
    assign signature = '0;
    logic unused_go;
    assign unused_go = go;
`endif
endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// tb_breadboard_sweep_ctrl: directed checks of sweep order, timing, backpressure, abort and reset.
module tb_breadboard_sweep_ctrl;
    logic clk = 0, rst = 1, start = 0, abort = 0, rd_ready = 1, const_mode = 0;
    logic [3:0] dut_in, rd_index;
    logic [9:0] dut_out, rd_data, signature;
    logic rd_valid, busy, done;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    assign dut_out = const_mode ? 10'h001 : {6'b0, dut_in};
    breadboard_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_index(rd_index), .rd_data(rd_data),
        .busy(busy), .done(done), .signature(signature)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask
    task automatic collect(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            bit got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                if (rd_valid && rd_ready) begin
                    check("idx", rd_index, k);
                    check("data", rd_data, const_mode ? 1 : k);
                    got = 1;
                end
                step();
            end
            check("handshake_seen", got, 1);
        end
    endtask
    task automatic wait_valid();
        for (int t = 0; t < 20 && !rd_valid; t++) step();
        check("valid_seen", rd_valid, 1);
    endtask
    initial begin
        int nres, done_cyc, ndone, busy_bad;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_index", rd_index, 0);
        check("rst_data", rd_data, 0);
        check("rst_sig", signature, 0);
        rst = 0;
        step();
        // nominal sweep with exact cycle accounting from the start edge
        pulse_start();
        nres = 0; done_cyc = 0; ndone = 0; busy_bad = 0;
        for (int c = 1; c <= 67; c++) begin
            if (busy != (c <= 65)) busy_bad++;
            if (done) begin done_cyc = c; ndone++; end
            if (rd_valid) begin
                check("nom_idx", rd_index, nres);
                check("nom_data", rd_data, nres);
                nres++;
            end
            step();
        end
        check("nom_count", nres, 16);
        check("nom_done_cycle", done_cyc, 65);
        check("nom_done_pulses", ndone, 1);
        check("nom_busy_window", busy_bad, 0);
        // backpressure at index 5 with a stray start during the stall
        pulse_start();
        collect(0, 4);
        wait_valid();
        rd_ready = 0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", rd_valid, 1);
            check("bp_idx", rd_index, 5);
            check("bp_data", rd_data, 10'h005);
            check("bp_dut_in", dut_in, 5);
            start = (i == 3);
            step();
        end
        start = 0;
        rd_ready = 1;
        collect(5, 15);
        check("bp_done", done, 1);
        step();
        check("bp_idle", busy, 0);
        // abort at index 7 while settling
        pulse_start();
        collect(0, 6);
        check("ab_pre_dut_in", dut_in, 7);
        check("ab_pre_valid", rd_valid, 0);
        abort = 1;
        step();
        abort = 0;
        check("ab_busy", busy, 0);
        check("ab_valid", rd_valid, 0);
        check("ab_dut_in", dut_in, 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            step();
        end
        check("ab_no_done", ndone, 0);
        pulse_start();
        collect(0, 15);
        check("ab_restart_done", done, 1);
        step();
        // start and abort together in IDLE
        start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        check("coll_busy", busy, 0);
        step();
        check("coll_busy2", busy, 0);
        check("coll_dut_in", dut_in, 0);
        // synchronous reset while waiting in EMIT at index 12
        pulse_start();
        collect(0, 11);
        rd_ready = 0;
        wait_valid();
        check("rs_idx_pre", rd_index, 12);
        rst = 1;
        step();
        rst = 0;
        rd_ready = 1;
        check("rs_busy", busy, 0);
        check("rs_valid", rd_valid, 0);
        check("rs_done", done, 0);
        check("rs_dut_in", dut_in, 0);
        check("rs_idx", rd_index, 0);
        check("rs_data", rd_data, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) ndone++;
            step();
        end
        check("rs_stays_idle", ndone, 0);
        // signature over a constant breadboard output of 1
        const_mode = 1;
        pulse_start();
        collect(0, 15);
        check("sig_done", done, 1);
`ifdef SWEEP_SIGNATURE_EN
        check("sig_value", signature, 10'h3C0);
`else
        check("sig_value", signature, 0);
`endif
        step();
        const_mode = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
